// File: rtl/pet_prg_pkg.sv
// Shared types and constants for the PET .PRG loader.
package pet_prg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_LO,
    HDR_HI,
    DATA,
    PTR,
    DONE,
    ERR
  } prg_state_t;

  localparam logic [1:0] PRG_ERR_NONE  = 2'd0;
  localparam logic [1:0] PRG_ERR_SHORT = 2'd1;
  localparam logic [1:0] PRG_ERR_ADDR  = 2'd2;
  localparam logic [1:0] PRG_ERR_OVF   = 2'd3;

  localparam logic [7:0] ZP_TXTTAB = 8'h28;
  localparam logic [7:0] ZP_VARTAB = 8'h2A;

endpackage

// File: rtl/pet_prg_loader.sv
// Streams a .PRG image from the host download channel into PET RAM via the DMA port.
// Define PRG_PTR_FIXUP_EN to patch the BASIC end-of-program pointers after a load.
module pet_prg_loader
  import pet_prg_pkg::*;
#(
  parameter logic [7:0]  PTR_BASE = ZP_VARTAB,
  parameter int unsigned NUM_PTRS = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dl_start,
  input  logic        dl_abort,
  input  logic        dl_valid,
  input  logic [7:0]  dl_data,
  input  logic        dl_last,
  output logic        dl_ready,
  output logic [14:0] dma_addr,
  output logic [7:0]  dma_din,
  output logic        dma_we,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [15:0] end_addr
);

  // Pointers must stay inside zero page.
  if (NUM_PTRS < 1 || NUM_PTRS > 4 || 32'(PTR_BASE) + 2 * NUM_PTRS > 256) begin : g_bad_cfg
    $error("pet_prg_loader: PTR_BASE/NUM_PTRS out of range");
  end

  prg_state_t  r_state, w_state;
  logic [15:0] r_cur_addr, w_cur_addr;
  logic [15:0] r_end_addr, w_end_addr;
  logic [1:0]  r_err_code, w_err_code;
  logic        r_dl_ready, w_dl_ready;
  logic        r_dma_we, w_dma_we;
  logic [14:0] r_dma_addr, w_dma_addr;
  logic [7:0]  r_dma_din, w_dma_din;
  logic        r_busy, w_busy;
  logic        r_done, w_done;
  logic        r_error, w_error;
  logic        w_accept;

`ifdef PRG_PTR_FIXUP_EN
  localparam int unsigned PTR_WRITES = 2 * NUM_PTRS;
  localparam int unsigned PTR_IDX_W  = 3;
  logic [PTR_IDX_W-1:0] r_ptr_idx, w_ptr_idx;
`endif

  assign w_accept = dl_valid && r_dl_ready;

  // Next-state and next-output logic.
  always_comb begin
    w_state    = r_state;
    w_cur_addr = r_cur_addr;
    w_end_addr = r_end_addr;
    w_err_code = r_err_code;
    w_dma_we   = 1'b0;
    w_dma_addr = r_dma_addr;
    w_dma_din  = r_dma_din;
    // Status flags follow the settled state one cycle later.
    w_done     = (r_state == DONE);
    w_error    = (r_state == ERR);
`ifdef PRG_PTR_FIXUP_EN
    w_ptr_idx  = r_ptr_idx;
`endif

    case (r_state)
      IDLE, DONE, ERR: begin
        if (dl_start) begin
          w_state    = HDR_LO;
          w_err_code = PRG_ERR_NONE;
          w_done     = 1'b0;
          w_error    = 1'b0;
        end
      end
      HDR_LO: begin
        if (w_accept) begin
          w_cur_addr[7:0] = dl_data;
          if (dl_last) begin
            w_state    = ERR;
            w_err_code = PRG_ERR_SHORT;
          end else begin
            w_state = HDR_HI;
          end
        end
      end
      HDR_HI: begin
        if (w_accept) begin
          w_cur_addr[15:8] = dl_data;
          if (dl_data[7]) begin
            w_state    = ERR;
            w_err_code = PRG_ERR_ADDR;
          end else begin
            w_end_addr = {dl_data, r_cur_addr[7:0]};
            w_state    = dl_last ? DONE : DATA;
          end
        end
      end
      DATA: begin
        if (w_accept) begin
          if (r_cur_addr[15]) begin
            w_state    = ERR;
            w_err_code = PRG_ERR_OVF;
          end else begin
            w_dma_we   = 1'b1;
            w_dma_addr = r_cur_addr[14:0];
            w_dma_din  = dl_data;
            w_cur_addr = r_cur_addr + 16'd1;
            w_end_addr = r_cur_addr + 16'd1;
            if (dl_last) begin
`ifdef PRG_PTR_FIXUP_EN
              w_state   = PTR;
              w_ptr_idx = '0;
`else
              w_state   = DONE;
`endif
            end
          end
        end
      end
`ifdef PRG_PTR_FIXUP_EN
      PTR: begin
        w_dma_we   = 1'b1;
        w_dma_addr = {7'd0, PTR_BASE + {5'd0, r_ptr_idx}};
        w_dma_din  = r_ptr_idx[0] ? r_end_addr[15:8] : r_end_addr[7:0];
        if (r_ptr_idx == PTR_IDX_W'(PTR_WRITES - 1)) begin
          w_state = DONE;
        end else begin
          w_ptr_idx = r_ptr_idx + PTR_IDX_W'(1);
        end
      end
`endif
      default: w_state = IDLE;
    endcase

    // Abort wins over everything, including a byte accepted this cycle.
    if (dl_abort) begin
      w_state    = IDLE;
      w_dma_we   = 1'b0;
      w_err_code = PRG_ERR_NONE;
      w_done     = 1'b0;
      w_error    = 1'b0;
    end

    w_dl_ready = w_state inside {HDR_LO, HDR_HI, DATA};
    w_busy     = !(w_state inside {IDLE, DONE, ERR});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_cur_addr <= '0;
      r_end_addr <= '0;
      r_err_code <= PRG_ERR_NONE;
      r_dl_ready <= 1'b0;
      r_dma_we   <= 1'b0;
      r_dma_addr <= '0;
      r_dma_din  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
`ifdef PRG_PTR_FIXUP_EN
      r_ptr_idx  <= '0;
`endif
    end else begin
      r_state    <= w_state;
      r_cur_addr <= w_cur_addr;
      r_end_addr <= w_end_addr;
      r_err_code <= w_err_code;
      r_dl_ready <= w_dl_ready;
      r_dma_we   <= w_dma_we;
      r_dma_addr <= w_dma_addr;
      r_dma_din  <= w_dma_din;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_error    <= w_error;
`ifdef PRG_PTR_FIXUP_EN
      r_ptr_idx  <= w_ptr_idx;
`endif
    end
  end

  assign dl_ready = r_dl_ready;
  assign dma_we   = r_dma_we;
  assign dma_addr = r_dma_addr;
  assign dma_din  = r_dma_din;
  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;
  assign err_code = r_err_code;
  assign end_addr = r_end_addr;

endmodule
